// File: rtl/nand_tgt_pkg.sv
// Shared definitions for the NAND target model: opcodes, FSM states,
// bus-cycle classification, status bit positions and ID helpers.
package nand_tgt_pkg;

    // Command opcodes
    localparam logic [7:0] CMD_READ      = 8'h00;
    localparam logic [7:0] CMD_READ_CONF = 8'h30;
    localparam logic [7:0] CMD_PROG      = 8'h80;
    localparam logic [7:0] CMD_PROG_CONF = 8'h10;
    localparam logic [7:0] CMD_STATUS    = 8'h70;
    localparam logic [7:0] CMD_READ_ID   = 8'h90;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    // READ ID address selectors
    localparam logic [7:0] ID_SRC_MFR  = 8'h00;
    localparam logic [7:0] ID_SRC_ONFI = 8'h20;

    // Status register bit positions
    localparam int unsigned STAT_BIT_WP   = 7;
    localparam int unsigned STAT_BIT_RDY  = 6;
    localparam int unsigned STAT_BIT_ARDY = 5;
    localparam int unsigned STAT_BIT_FAIL = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ID_ADDR  = 4'd1,
        ST_RD_ADDR  = 4'd2,
        ST_RD_WAIT  = 4'd3,
        ST_PG_ADDR  = 4'd4,
        ST_PG_DATA  = 4'd5,
        ST_BUSY_RD  = 4'd6,
        ST_BUSY_PG  = 4'd7,
        ST_BUSY_RST = 4'd8,
        ST_OUT_ID   = 4'd9,
        ST_OUT_STAT = 4'd10,
        ST_OUT_PAGE = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CYC_IDLE = 3'd0,
        CYC_CMD  = 3'd1,
        CYC_ADDR = 3'd2,
        CYC_DIN  = 3'd3,
        CYC_DOUT = 3'd4
    } cyc_t;

    // Classify one sampled bus cycle; everything is idle while CE# is high
    function automatic cyc_t decode_cycle(input logic cen, input logic cle,
                                          input logic ale, input logic wrn);
        cyc_t c;
        c = CYC_IDLE;
        if (!cen) begin
            case ({cle, ale, wrn})
                3'b101:  c = CYC_CMD;
                3'b011:  c = CYC_ADDR;
                3'b111:  c = CYC_DIN;
                3'b110:  c = CYC_DOUT;
                default: c = CYC_IDLE;
            endcase
        end
        return c;
    endfunction

    // ONFI signature bytes "ONFI" in the order the host reads them
    function automatic logic [7:0] onfi_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h4F;
            2'd1:    b = 8'h4E;
            2'd2:    b = 8'h46;
            default: b = 8'h49;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nand_tgt_busy_timer.sv
// Loadable 16-bit busy down-counter. done is high during the last busy
// cycle; idx counts elapsed busy cycles from 0 so the parent can step
// through page bytes while busy.
module nand_tgt_busy_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done,
    output logic [15:0] idx
);

    logic [15:0] count;

    // Count down from the loaded value while tracking elapsed cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idx   <= '0;
        end else if (load) begin
            count <= load_val;
            idx   <= '0;
        end else if (count != '0) begin
            count <= count - 16'd1;
            idx   <= idx + 16'd1;
        end
    end

    assign done = (count == 16'd1);

endmodule

// File: rtl/nand_target_model.sv
// Single-target NAND flash responder (device side of the CLE/ALE/W-R#/CE#/DQ
// bus). Optional macro NAND_TGT_WP_EN enables write protect via v_wpn.
module nand_target_model
    import nand_tgt_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = 64,
    parameter int unsigned NUM_PAGES  = 4,
    parameter int unsigned T_R        = 80,
    parameter int unsigned T_PROG     = 120,
    parameter int unsigned T_RST      = 16,
    parameter logic [31:0] ID_WORD    = 32'h00A5_642C
) (
    input  logic       v_clk0,
    input  logic       v_rst0,
    input  logic       v_cen,
    input  logic       v_cle,
    input  logic       v_ale,
    input  logic       v_wrn,
    input  logic       v_wpn,
    input  logic [7:0] v_dq_in,
    output logic [7:0] v_dq_out,
    output logic       v_dq_oe,
    output logic       v_dqs_out,
    output logic       v_rb,
    output logic [7:0] v_debug
);

    localparam int unsigned COLW        = $clog2(PAGE_BYTES);
    localparam int unsigned ROWW        = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int unsigned ARRAY_BYTES = NUM_PAGES * PAGE_BYTES;
    localparam int unsigned AW          = $clog2(ARRAY_BYTES);
    localparam logic [15:0] T_R16       = 16'(T_R);
    localparam logic [15:0] T_PROG16    = 16'(T_PROG);
    localparam logic [15:0] T_RST16     = 16'(T_RST);
    localparam logic [15:0] PAGE16      = 16'(PAGE_BYTES);
    localparam logic [15:0] PG_COMMIT   = 16'(T_PROG - PAGE_BYTES);

    logic [7:0] array_mem [ARRAY_BYTES];
    logic [7:0] page_reg  [PAGE_BYTES];

    state_t          state;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic [1:0]      addr_cnt;
    logic [1:0]      id_idx;
    logic [7:0]      id_sel;
    logic            stat_mode;
    logic            fail;
    logic            prog_ok;

    cyc_t            cyc;
    logic            busy_st;
    logic            abort;
    logic            tmr_load;
    logic [15:0]     tmr_val;
    logic            tmr_done;
    logic [15:0]     tmr_idx;
    logic            wp_ok;
    logic [7:0]      status_byte;
    logic [7:0]      id_byte;
    logic [7:0]      dout_byte;
    logic [COLW-1:0] pg_off;
    logic            arr_we;

`ifdef NAND_TGT_WP_EN
    assign wp_ok = v_wpn;
`else
    logic unused_wpn;
    assign wp_ok      = 1'b1;
    assign unused_wpn = v_wpn;
`endif

    assign cyc     = decode_cycle(v_cen, v_cle, v_ale, v_wrn);
    assign busy_st = (state == ST_BUSY_RD) || (state == ST_BUSY_PG) || (state == ST_BUSY_RST);
    assign abort   = (cyc == CYC_CMD) && (v_dq_in == CMD_RESET);
    assign pg_off  = COLW'(tmr_idx - PG_COMMIT);
    assign v_debug = {state, fail, ~v_rb, 2'b00};

    nand_tgt_busy_timer u_timer (
        .clk      (v_clk0),
        .rst      (v_rst0),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .idx      (tmr_idx)
    );

    // Timer load on entry to any busy state; 0xFF restarts it from anywhere
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (abort) begin
            tmr_load = 1'b1;
            tmr_val  = T_RST16;
        end else if (cyc == CYC_CMD && !busy_st) begin
            if (state == ST_RD_WAIT && v_dq_in == CMD_READ_CONF) begin
                tmr_load = 1'b1;
                tmr_val  = T_R16;
            end else if (state == ST_PG_DATA && v_dq_in == CMD_PROG_CONF) begin
                tmr_load = 1'b1;
                tmr_val  = T_PROG16;
            end
        end
    end

    // Status, ID and output byte selection for the next DOUT cycle
    always_comb begin
        status_byte                = '0;
        status_byte[STAT_BIT_WP]   = wp_ok;
        status_byte[STAT_BIT_RDY]  = ~busy_st;
        status_byte[STAT_BIT_ARDY] = ~busy_st;
        status_byte[STAT_BIT_FAIL] = fail;

        id_byte = 8'h00;
        if (id_sel == ID_SRC_MFR)
            id_byte = ID_WORD[{id_idx, 3'b000} +: 8];
        else if (id_sel == ID_SRC_ONFI)
            id_byte = onfi_byte(id_idx);

        dout_byte = 8'h00;
        if (stat_mode)
            dout_byte = status_byte;
        else if (state == ST_OUT_ID)
            dout_byte = id_byte;
        else if (state == ST_OUT_PAGE)
            dout_byte = page_reg[col];
    end

    // Array commit uses only the last PAGE_BYTES cycles of program busy, so
    // a 0xFF issued early in the program leaves the stored page untouched.
    assign arr_we = (state == ST_BUSY_PG) && prog_ok && (tmr_idx >= PG_COMMIT) && !abort;

    // Page array: written from the page register at the tail of a program
    always_ff @(posedge v_clk0) begin
        if (arr_we)
            array_mem[AW'({row, pg_off})] <= page_reg[pg_off];
    end

    // Page register: host data-in during PG_DATA, array fill during read busy
    always_ff @(posedge v_clk0) begin
        if (state == ST_PG_DATA && cyc == CYC_DIN)
            page_reg[col] <= v_dq_in;
        else if (state == ST_BUSY_RD && tmr_idx < PAGE16)
            page_reg[tmr_idx[COLW-1:0]] <= array_mem[AW'({row, tmr_idx[COLW-1:0]})];
    end

    // Bus-cycle FSM: command/address decode, busy sequencing, registered DQ/DQS/R-B
    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            addr_cnt  <= '0;
            id_idx    <= '0;
            id_sel    <= '0;
            stat_mode <= 1'b0;
            fail      <= 1'b0;
            prog_ok   <= 1'b1;
            v_rb      <= 1'b1;
            v_dq_out  <= '0;
            v_dq_oe   <= 1'b0;
            v_dqs_out <= 1'b0;
        end else begin
            if (cyc == CYC_DOUT && (!busy_st || stat_mode)) begin
                v_dq_out  <= dout_byte;
                v_dq_oe   <= 1'b1;
                v_dqs_out <= ~v_dqs_out;
                if (!stat_mode) begin
                    if (state == ST_OUT_ID)
                        id_idx <= id_idx + 2'd1;
                    if (state == ST_OUT_PAGE)
                        col <= col + COLW'(1);
                end
            end else begin
                v_dq_oe <= 1'b0;
            end

            if (busy_st && tmr_done) begin
                state <= (state == ST_BUSY_RD) ? ST_OUT_PAGE : ST_IDLE;
                v_rb  <= 1'b1;
            end

            case (cyc)
                CYC_CMD: begin
                    if (v_dq_in == CMD_RESET) begin
                        state     <= ST_BUSY_RST;
                        fail      <= 1'b0;
                        stat_mode <= 1'b0;
                        v_rb      <= 1'b0;
                    end else if (v_dq_in == CMD_STATUS) begin
                        stat_mode <= 1'b1;
                    end else if (!busy_st) begin
                        stat_mode <= 1'b0;
                        case (v_dq_in)
                            CMD_READ: begin
                                state    <= ST_RD_ADDR;
                                addr_cnt <= '0;
                            end
                            CMD_PROG: begin
                                state    <= ST_PG_ADDR;
                                addr_cnt <= '0;
                            end
                            CMD_READ_ID: state <= ST_ID_ADDR;
                            CMD_READ_CONF: begin
                                if (state == ST_RD_WAIT) begin
                                    state <= ST_BUSY_RD;
                                    v_rb  <= 1'b0;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                            CMD_PROG_CONF: begin
                                if (state == ST_PG_DATA) begin
                                    state   <= ST_BUSY_PG;
                                    v_rb    <= 1'b0;
                                    prog_ok <= wp_ok;
                                    fail    <= ~wp_ok;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                CYC_ADDR: begin
                    if (state == ST_ID_ADDR) begin
                        id_sel <= v_dq_in;
                        id_idx <= '0;
                        state  <= ST_OUT_ID;
                    end else if (state == ST_RD_ADDR || state == ST_PG_ADDR) begin
                        addr_cnt <= addr_cnt + 2'd1;
                        case (addr_cnt)
                            2'd0: col <= v_dq_in[COLW-1:0];
                            2'd1: ;
                            default: begin
                                row   <= v_dq_in[ROWW-1:0];
                                state <= (state == ST_RD_ADDR) ? ST_RD_WAIT : ST_PG_DATA;
                            end
                        endcase
                    end
                end
                CYC_DIN: begin
                    if (state == ST_PG_DATA)
                        col <= col + COLW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_target_model.sv
// Directed self-checking bench for nand_target_model.
module tb_nand_target_model;

    logic       clk = 1'b0;
    logic       v_rst0;
    logic       v_cen;
    logic       v_cle;
    logic       v_ale;
    logic       v_wrn;
    logic       v_wpn;
    logic [7:0] v_dq_in;
    logic [7:0] v_dq_out;
    logic       v_dq_oe;
    logic       v_dqs_out;
    logic       v_rb;
    logic [7:0] v_debug;

    int  checks = 0;
    int  errors = 0;
    logic exp_dqs = 1'b0;
    int  n_busy;

    always #5 clk = ~clk;

    nand_target_model #(
        .PAGE_BYTES (64),
        .NUM_PAGES  (4),
        .T_R        (80),
        .T_PROG     (120),
        .T_RST      (16),
        .ID_WORD    (32'h00A5_642C)
    ) dut (
        .v_clk0    (clk),
        .v_rst0    (v_rst0),
        .v_cen     (v_cen),
        .v_cle     (v_cle),
        .v_ale     (v_ale),
        .v_wrn     (v_wrn),
        .v_wpn     (v_wpn),
        .v_dq_in   (v_dq_in),
        .v_dq_out  (v_dq_out),
        .v_dq_oe   (v_dq_oe),
        .v_dqs_out (v_dqs_out),
        .v_rb      (v_rb),
        .v_debug   (v_debug)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One sampled bus cycle; outputs are stable 1 time unit after the edge
    task automatic drive(input logic cen, input logic cle, input logic ale,
                         input logic wrn, input logic [7:0] dq);
        v_cen = cen; v_cle = cle; v_ale = ale; v_wrn = wrn; v_dq_in = dq;
        @(posedge clk);
        #1;
        v_cen = 1'b0; v_cle = 1'b0; v_ale = 1'b0; v_wrn = 1'b1; v_dq_in = 8'h00;
    endtask

    task automatic cmd(input logic [7:0] b);  drive(1'b0, 1'b1, 1'b0, 1'b1, b); endtask
    task automatic addr(input logic [7:0] b); drive(1'b0, 1'b0, 1'b1, 1'b1, b); endtask
    task automatic din(input logic [7:0] b);  drive(1'b0, 1'b1, 1'b1, 1'b1, b); endtask
    task automatic idle_cyc();                drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); endtask

    task automatic dout_chk(input string tag, input logic [7:0] exp);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        exp_dqs = ~exp_dqs;
        check(tag, {24'h0, v_dq_out}, {24'h0, exp});
        check({tag, "_oe"}, {31'h0, v_dq_oe}, 32'h1);
        check({tag, "_dqs"}, {31'h0, v_dqs_out}, {31'h0, exp_dqs});
    endtask

    // Count cycles with R/B# low, bounded so a stuck busy cannot hang the run
    task automatic busy_len(output int n);
        n = 0;
        while (v_rb === 1'b0 && n < 2000) begin
            n++;
            idle_cyc();
        end
    endtask

    initial begin
        v_rst0 = 1'b1; v_cen = 1'b1; v_cle = 1'b0; v_ale = 1'b0;
        v_wrn = 1'b1; v_wpn = 1'b1; v_dq_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        v_rst0 = 1'b0;

        // Reset state
        check("rst_dq_out", {24'h0, v_dq_out}, 32'h0);
        check("rst_oe", {31'h0, v_dq_oe}, 32'h0);
        check("rst_dqs", {31'h0, v_dqs_out}, 32'h0);
        check("rst_rb", {31'h0, v_rb}, 32'h1);
        check("rst_debug", {24'h0, v_debug}, 32'h00);

        // Manufacturer ID, LSB first, index wraps after 4 bytes
        cmd(8'h90); addr(8'h00);
        dout_chk("id0", 8'h2C);
        dout_chk("id1", 8'h64);
        dout_chk("id2", 8'hA5);
        dout_chk("id3", 8'h00);
        dout_chk("id_wrap", 8'h2C);
        idle_cyc();
        check("id_oe_drop", {31'h0, v_dq_oe}, 32'h0);

        // ONFI signature
        cmd(8'h90); addr(8'h20);
        dout_chk("onfi0", 8'h4F);
        dout_chk("onfi1", 8'h4E);
        idle_cyc();

        // Program page 1 starting at column 62, wrapping to column 0
        cmd(8'h80); addr(8'h3E); addr(8'h00); addr(8'h01);
        din(8'h11); din(8'h22); din(8'h33);
        cmd(8'h10);
        check("pg_debug_busy", {24'h0, v_debug}, 32'h74);
        busy_len(n_busy);
        check("pg_busy_len", n_busy, 120);

        cmd(8'h70);
        dout_chk("stat_ready", 8'hE0);
        idle_cyc();

        // Read back page 1; a CE#-high cycle mid-address must be ignored
        cmd(8'h00); addr(8'h3E);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        check("cen_hold_rb", {31'h0, v_rb}, 32'h1);
        addr(8'h00); addr(8'h01); addr(8'h03);
        cmd(8'h30);
        busy_len(n_busy);
        check("rd_busy_len", n_busy, 80);
        dout_chk("rd0", 8'h11);
        dout_chk("rd1", 8'h22);
        dout_chk("rd2_wrap", 8'h33);
        idle_cyc();

        // Status polled during read busy, then after ready
        cmd(8'h00); addr(8'h3E); addr(8'h00); addr(8'h01);
        cmd(8'h30);
        cmd(8'h70);
        dout_chk("stat_busy", 8'h80);
        busy_len(n_busy);
        check("stat_wait_bound", {31'h0, v_rb}, 32'h1);
        dout_chk("stat_after", 8'hE0);
        idle_cyc();

        // Reset aborts program at busy cycle 10; page must keep old data
        cmd(8'h80); addr(8'h3E); addr(8'h00); addr(8'h01);
        din(8'hAA); din(8'hBB); din(8'hCC);
        cmd(8'h10);
        repeat (9) idle_cyc();
        cmd(8'hFF);
        busy_len(n_busy);
        check("rst_busy_len", n_busy, 16);
        check("abort_debug_idle", {24'h0, v_debug}, 32'h00);
        cmd(8'h00); addr(8'h3E); addr(8'h00); addr(8'h01);
        cmd(8'h30);
        busy_len(n_busy);
        dout_chk("abort_rd0", 8'h11);
        dout_chk("abort_rd1", 8'h22);
        dout_chk("abort_rd2", 8'h33);
        idle_cyc();

        // Unknown command returns to IDLE; DOUT there drives 0x00
        cmd(8'h55);
        dout_chk("unk_dout", 8'h00);
        check("unk_rb", {31'h0, v_rb}, 32'h1);
        check("unk_debug", {24'h0, v_debug}, 32'h00);
        idle_cyc();

`ifdef NAND_TGT_WP_EN
        // Write-protected program fails and leaves old page data
        cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h02);
        din(8'h5A);
        cmd(8'h10);
        busy_len(n_busy);
        v_wpn = 1'b0;
        cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h02);
        din(8'hA5);
        cmd(8'h10);
        busy_len(n_busy);
        check("wp_busy_len", n_busy, 120);
        cmd(8'h70);
        dout_chk("wp_stat", 8'h61);
        idle_cyc();
        v_wpn = 1'b1;
        cmd(8'h00); addr(8'h00); addr(8'h00); addr(8'h02);
        cmd(8'h30);
        busy_len(n_busy);
        dout_chk("wp_rd_old", 8'h5A);
        idle_cyc();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the directed sequence somehow stalls
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no end of sequence, expected finish");
        $fatal(1, "timeout");
    end

endmodule
